ddc_stream_arbiter: RTL
=======================

Name: ddc_stream_arbiter

Overview:
- Packet-granular round-robin arbiter. Shares one 128-bit AXI4-Stream DMA path among N_CH DDC channel streams.
- Grants one channel for exactly one packet of packet_length beats, then re-arbitrates.
- Generates m_axis_tlast on the last beat and tags each packet with its channel index on m_axis_tuser.
- Sits between the per-channel DDC outputs and the DMA engine.

Parameters:
N_CH, 4, number of input channels (2..8)
CH_W, 2, width of the channel index; must satisfy 2**CH_W >= N_CH
C_WIDTH, 32, width of packet_length and the beat counter

Ports:
s_axis_aclk  in  1  single clock for all logic
s_axis_areset  in  1  asynchronous, active-high reset
packet_length  in  C_WIDTH  beats per packet; sampled at grant
ch_enable  in  N_CH  per-channel arbitration enable
s_axis_tdata  in  N_CH*128  packed channel data; channel i occupies bits [128*i+127:128*i]
s_axis_tvalid  in  N_CH  per-channel valid
s_axis_tready  out  N_CH  per-channel ready
m_axis_tdata  out  128  output data
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last beat of packet
m_axis_tuser  out  CH_W  index of the granted channel
busy  out  1  high while a packet is in progress
pkt_count  out  32  completed-packet counter (optional feature)

Behaviour:
- Reset is asynchronous, active-high. It forces:
  - state = IDLE, beat counter = 0, latched length = 0, grant = 0;
  - last_grant = N_CH-1, so channel 0 has first priority;
  - pkt_count = 0.
- Outputs in IDLE:
  - all s_axis_tready = 0; m_axis_tvalid = 0; m_axis_tlast = 0; busy = 0;
  - m_axis_tdata and m_axis_tuser are don't-care (implementation drives channel `grant`).
- State IDLE:
  - Search order: last_grant+1, last_grant+2, ... mod N_CH.
  - The first channel i with s_axis_tvalid[i] & ch_enable[i] is selected.
  - On a match, register grant = i, latch len = max(packet_length, 1), clear the counter, and go to STREAM.
  - The transition costs 1 cycle. No data moves in the IDLE cycle.
- State STREAM: the datapath is combinational (zero latency).
  - m_axis_tdata = channel grant data; m_axis_tvalid = s_axis_tvalid[grant].
  - s_axis_tready[grant] = m_axis_tready; all other tready = 0.
  - m_axis_tuser = grant; busy = 1.
  - m_axis_tlast = (counter == len-1) & s_axis_tvalid[grant].
  - On a handshake (m_axis_tready & s_axis_tvalid[grant]):
    - not last: counter += 1;
    - last: counter = 0, last_grant = grant, pkt_count += 1, go to IDLE.
- Fairness:
  - A channel holding valid is served within N_CH packets.
  - Back-to-back packets therefore have a 1-cycle gap.
- Boundary conditions:
  - packet_length = 0 is treated as 1: tlast on every beat.
  - packet_length changing mid-packet has no effect; the latched len is used until the packet ends.
  - ch_enable deasserted for the granted channel mid-packet: the packet completes normally, and the channel is excluded from the next arbitration.
  - A granted channel dropping tvalid mid-packet: the grant is held and the arbiter waits. There is no timeout and no preemption.
  - m_axis_tready low: the counter holds and all tready are 0.
  - Counter width is C_WIDTH. len up to 2**C_WIDTH-1 is supported; the counter never wraps inside a packet.
  - pkt_count wraps 2**32-1 -> 0.
  - Reset mid-packet: the packet is abandoned and no tlast is emitted. After release, arbitration restarts from channel 0.
  - No requester enabled: stay in IDLE.

Optional Feature:
- Macro: ARB_PKT_COUNT_EN.
- Defined: pkt_count is a 32-bit register, incremented on each tlast handshake, cleared by reset, wrapping.
- Undefined: the pkt_count port remains present but is tied to 0, and no counter logic is synthesized.

Test Plan:
- Single channel: N_CH=4, packet_length=4, only ch0 valid, m_axis_tready=1.
  - tlast on beats 4, 8, 12; tuser=0; a 1-cycle gap between packets.
  - pkt_count=3 after 12 beats when ARB_PKT_COUNT_EN is defined.
- Round robin: all 4 channels valid continuously, packet_length=2.
  - Packet order ch0, ch1, ch2, ch3, ch0.
  - Each packet is exactly 2 beats, with tuser matching its channel.
- Backpressure: packet_length=8, m_axis_tready toggled 1-0-1-0.
  - Exactly 8 handshakes before tlast.
  - No beat is duplicated or dropped; data from an incrementing source is contiguous.
- Mid-packet changes: packet_length 4->16 and ch_enable[grant] cleared after beat 2.
  - The current packet ends at beat 4.
  - The next grant skips that channel; the following packet is 16 beats.
- Zero length and async reset:
  - packet_length=0: tlast on every beat.
  - Assert s_axis_areset between clock edges at beat 3 of a 6-beat packet: all outputs are 0 immediately, busy=0.
  - After release with ch0 and ch2 valid, ch0 is granted first.

Source files
------------

// File: rtl/ddc_stream_arbiter.sv
// -----------------------------------------------------------------------------
// ddc_stream_arbiter
//
// Packet-granular round-robin arbiter. It shares one 128-bit AXI4-Stream DMA
// path among N_CH DDC channel streams. One channel is granted for exactly one
// packet of packet_length beats (0 is treated as 1). m_axis_tlast is generated
// on the final beat, and every beat is tagged with the channel index on
// m_axis_tuser. After each packet the arbiter spends one IDLE cycle
// re-arbitrating. The search starts just after the last served channel.
//
// Handshake contract: a beat transfers on a rising clock edge where
// m_axis_tvalid and m_axis_tready are both high. In STREAM the granted
// channel's valid/ready are wired straight through to the master side, with
// zero latency. Every non-granted channel sees tready = 0, and so does every
// channel while in IDLE.
//
// Optional feature (compile-time macro ARB_PKT_COUNT_EN):
//   defined   : pkt_count is a wrapping 32-bit count of completed packets
//               (tlast handshakes), cleared by reset.
//   undefined : pkt_count is tied to 0 and no counter is built.
//
// Parameters:
//   N_CH     number of input channels (2..8)
//   CH_W     channel index width, 2**CH_W >= N_CH
//   C_WIDTH  width of packet_length and of the beat counter
//
// Ports:
//   s_axis_aclk    clock for all logic
//   s_axis_areset  asynchronous active-high reset
//   packet_length  beats per packet, sampled when a grant is made
//   ch_enable      per-channel arbitration enable
//   s_axis_tdata   packed channel data, channel i at [128*i+127:128*i]
//   s_axis_tvalid  per-channel valid
//   s_axis_tready  per-channel ready
//   m_axis_tdata   output data (granted channel)
//   m_axis_tvalid  output valid
//   m_axis_tready  output ready
//   m_axis_tlast   last beat of the current packet
//   m_axis_tuser   index of the granted channel
//   busy           high while a packet is in progress
//   pkt_count      completed-packet counter (see ARB_PKT_COUNT_EN)
//   dbg_state      FSM state: 0 = IDLE, 1 = STREAM
// -----------------------------------------------------------------------------
module ddc_stream_arbiter #(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int C_WIDTH = 32
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_areset,
    input  logic [C_WIDTH-1:0]    packet_length,
    input  logic [N_CH-1:0]       ch_enable,
    input  logic [N_CH*128-1:0]   s_axis_tdata,
    input  logic [N_CH-1:0]       s_axis_tvalid,
    output logic [N_CH-1:0]       s_axis_tready,
    output logic [127:0]          m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CH_W-1:0]       m_axis_tuser,
    output logic                  busy,
    output logic [31:0]           pkt_count,
    output logic                  dbg_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // After reset, last_grant points at the highest channel so that channel 0
    // is searched first.
    localparam logic [CH_W-1:0]    LAST_INIT = CH_W'(N_CH - 1);
    localparam logic [CH_W:0]      N_R       = (CH_W+1)'(N_CH);
    localparam logic [CH_W:0]      ONE_R     = (CH_W+1)'(1);
    localparam logic [C_WIDTH-1:0] ONE_C     = C_WIDTH'(1);

    state_t               state_q;
    logic [CH_W-1:0]      grant_q;
    logic [CH_W-1:0]      last_grant_q;
    logic [C_WIDTH-1:0]   len_q;
    logic [C_WIDTH-1:0]   cnt_q;
    logic [C_WIDTH-1:0]   len_d;

    logic [N_CH-1:0]      req;
    logic                 arb_hit;
    logic [CH_W-1:0]      arb_sel;
    logic [CH_W:0]        rank;
    logic [CH_W:0]        best_rank;

    logic                 in_stream;
    logic [127:0]         g_data;
    logic                 g_valid;
    logic                 last_beat;
    logic                 handshake;
    logic                 pkt_done;

    assign req       = s_axis_tvalid & ch_enable;
    assign in_stream = (state_q == STREAM);

    // A zero length would never produce tlast, so it is promoted to one beat.
    assign len_d = (packet_length == '0) ? ONE_C : packet_length;

    // Round-robin pick. Each channel gets a rank equal to its distance from
    // last_grant+1 (mod N_CH), and the requesting channel with the lowest rank
    // wins. Working with ranks keeps every vector select constant and also
    // handles N_CH values that are not a power of two.
    always_comb begin
        arb_hit   = 1'b0;
        arb_sel   = '0;
        best_rank = '0;
        rank      = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (CH_W'(i) > last_grant_q) begin
                rank = (CH_W+1)'(i) - {1'b0, last_grant_q} - ONE_R;
            end else begin
                rank = (CH_W+1)'(i) + N_R - {1'b0, last_grant_q} - ONE_R;
            end
            if (req[i] && (!arb_hit || (rank < best_rank))) begin
                arb_hit   = 1'b1;
                arb_sel   = CH_W'(i);
                best_rank = rank;
            end
        end
    end

    // Granted-channel data/valid select. In IDLE the mux still follows grant_q.
    // Data is don't-care there, and valid is masked further down.
    always_comb begin
        g_data  = s_axis_tdata[127:0];
        g_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_q == CH_W'(i)) begin
                g_data  = s_axis_tdata[128*i +: 128];
                g_valid = s_axis_tvalid[i];
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < N_CH; i++) begin
            s_axis_tready[i] = in_stream && (grant_q == CH_W'(i)) && m_axis_tready;
        end
    end

    // len_q is at least 1 whenever in_stream is high, so len_q - 1 never
    // underflows where it matters.
    assign last_beat = (cnt_q == (len_q - ONE_C));
    assign handshake = in_stream && g_valid && m_axis_tready;
    assign pkt_done  = handshake && last_beat;

    assign m_axis_tdata  = g_data;
    assign m_axis_tvalid = in_stream && g_valid;
    assign m_axis_tlast  = in_stream && g_valid && last_beat;
    assign m_axis_tuser  = grant_q;
    assign busy          = in_stream;
    assign dbg_state     = state_q;

    // Arbitration / packet FSM. A granted channel that drops tvalid simply
    // stalls the packet: there is no timeout and no preemption.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_INIT;
            len_q        <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_hit) begin
                        grant_q <= arb_sel;
                        len_q   <= len_d;
                        cnt_q   <= '0;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (last_beat) begin
                            cnt_q        <= '0;
                            last_grant_q <= grant_q;
                            state_q      <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + ONE_C;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ARB_PKT_COUNT_EN
    logic [31:0] pkt_count_q;

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            pkt_count_q <= '0;
        end else if (pkt_done) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    logic unused_pkt_done;

    assign unused_pkt_done = pkt_done;
    assign pkt_count       = '0;
`endif

endmodule
